// File: rtl/proc_dispatcher.sv
// Packet dispatcher: buffers packet addresses in a FIFO, hands each one to an idle
// proc lane round-robin, reports completions lowest-lane-first, and grants a quiescent config window.
module proc_dispatcher #(
  parameter int NUM_PROC   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pkt_valid_i,
  input  logic [ADDR_W-1:0]                  pkt_addr_i,
  output logic                               pkt_ready_o,
  output logic [NUM_PROC-1:0]                proc_start_o,
  output logic [NUM_PROC*ADDR_W-1:0]         proc_pkt_addr_o,
  input  logic [NUM_PROC-1:0]                proc_ready_i,
  output logic                               done_valid_o,
  output logic [ADDR_W-1:0]                  done_addr_o,
  output logic [$clog2(NUM_PROC)-1:0]        done_proc_o,
  input  logic                               cfg_req_i,
  output logic                               cfg_grant_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

  localparam int LANE_W = $clog2(NUM_PROC);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [LANE_W:0]   NUM_LANES = (LANE_W+1)'(NUM_PROC);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_PROC-1);

  typedef enum logic [2:0] {
    L_IDLE,
    L_START,
    L_RUN,
    L_REPORT,
    L_RELEASE
  } lane_state_t;

  logic [ADDR_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push, pop;
  logic [ADDR_W-1:0] fifo_head;

  lane_state_t       state_q [NUM_PROC];
  logic [ADDR_W-1:0] addr_q  [NUM_PROC];
  logic [NUM_PROC-1:0] start_q;
  logic [NUM_PROC-1:0] lane_idle;
  logic                all_idle;

  logic [LANE_W-1:0] rr_q;
  logic [LANE_W:0]   cand;
  logic [LANE_W-1:0] cand_lane;
  logic              disp_found;
  logic [LANE_W-1:0] disp_lane;
  logic              dispatch_en;

  logic              cmp_found;
  logic [LANE_W-1:0] cmp_lane;

  logic              done_valid_q;
  logic [ADDR_W-1:0] done_addr_q;
  logic [LANE_W-1:0] done_proc_q;
  logic              cfg_grant_q;

  assign pkt_ready_o = (count_q < FULL_CNT);
  assign push        = pkt_valid_i & pkt_ready_o;
  assign pop         = dispatch_en;
  assign fifo_head   = fifo_mem_q[rd_ptr_q];

  // Storage carries no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= pkt_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PROC; i++) begin
      lane_idle[i] = (state_q[i] == L_IDLE);
    end
  end

  assign all_idle = &lane_idle;

  // Round-robin search: first idle lane at or after rr_q, wrapping modulo NUM_PROC.
  always_comb begin
    cand       = '0;
    cand_lane  = '0;
    disp_found = 1'b0;
    disp_lane  = '0;
    for (int k = 0; k < NUM_PROC; k++) begin
      cand = {1'b0, rr_q} + (LANE_W+1)'(k);
      if (cand >= NUM_LANES) begin
        cand = cand - NUM_LANES;
      end
      cand_lane = cand[LANE_W-1:0];
      if (!disp_found && lane_idle[cand_lane]) begin
        disp_found = 1'b1;
        disp_lane  = cand_lane;
      end
    end
  end

  assign dispatch_en = disp_found & (count_q != '0) & ~cfg_req_i & ~cfg_grant_q;

  // Scanning downward lets the lowest-indexed reporting lane overwrite the others.
  always_comb begin
    cmp_found = 1'b0;
    cmp_lane  = '0;
    for (int i = NUM_PROC-1; i >= 0; i--) begin
      if (state_q[i] == L_REPORT) begin
        cmp_found = 1'b1;
        cmp_lane  = LANE_W'(i);
      end
    end
  end

  // Lane FSMs; start stays high through REPORT so the proc parks in DONE until released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PROC; i++) begin
        state_q[i] <= L_IDLE;
        addr_q[i]  <= '0;
        start_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_PROC; i++) begin
        case (state_q[i])
          L_IDLE: begin
            if (dispatch_en && (disp_lane == LANE_W'(i))) begin
              state_q[i] <= L_START;
              addr_q[i]  <= fifo_head;
              start_q[i] <= 1'b1;
            end
          end
          L_START: begin
            state_q[i] <= L_RUN;
          end
          L_RUN: begin
            if (proc_ready_i[i]) begin
              state_q[i] <= L_REPORT;
            end
          end
          L_REPORT: begin
            if (cmp_found && (cmp_lane == LANE_W'(i))) begin
              state_q[i] <= L_RELEASE;
              start_q[i] <= 1'b0;
            end
          end
          L_RELEASE: begin
            state_q[i] <= L_IDLE;
          end
          default: begin
            state_q[i] <= L_IDLE;
            start_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= '0;
      done_valid_q <= 1'b0;
      done_addr_q  <= '0;
      done_proc_q  <= '0;
      cfg_grant_q  <= 1'b0;
    end else begin
      if (dispatch_en) begin
        rr_q <= (disp_lane == LAST_LANE) ? '0 : disp_lane + LANE_W'(1);
      end
      done_valid_q <= cmp_found;
      done_addr_q  <= cmp_found ? addr_q[cmp_lane] : '0;
      done_proc_q  <= cmp_found ? cmp_lane : '0;
      cfg_grant_q  <= cfg_req_i & all_idle;
    end
  end

  always_comb begin
    proc_pkt_addr_o = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      proc_pkt_addr_o[i*ADDR_W +: ADDR_W] = addr_q[i];
    end
  end

  assign proc_start_o = start_q;
  assign done_valid_o = done_valid_q;
  assign done_addr_o  = done_addr_q;
  assign done_proc_o  = done_proc_q;
  assign cfg_grant_o  = cfg_grant_q;
  assign fifo_count_o = count_q;

endmodule
